// File: rtl/fp_int_mul_serial_pkg.sv
// Shared definitions for the bit-serial FP x INT multiplier: format defaults, FSM states
// and the weight-precision clamp.
package fp_int_pkg;

  localparam int unsigned Fp16ExpW = 5;
  localparam int unsigned Fp16ManW = 10;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // A zero precision still consumes one (sign) bit; oversize requests saturate.
  function automatic int unsigned clamp_prec(input int unsigned prec,
                                             input int unsigned max_prec);
    if (prec == 0) return 1;
    if (prec > max_prec) return max_prec;
    return prec;
  endfunction

endpackage

// File: rtl/fp_int_mul_serial_if.sv
// Activation, weight-bit and result streams of the serial multiplier, plus the forward port.
interface fp_int_mul_serial_if
  import fp_int_pkg::*;
#(
  parameter int unsigned EXP_W    = Fp16ExpW,
  parameter int unsigned MAN_W    = Fp16ManW,
  parameter int unsigned MAX_PREC = 8,
  parameter int unsigned PREC_W   = 4
);
  localparam int unsigned ACT_W = 1 + EXP_W + MAN_W;
  localparam int unsigned MAG_W = MAN_W + 1 + MAX_PREC;

  logic [ACT_W-1:0]  act;
  logic [PREC_W-1:0] precision;
  logic              act_valid;
  logic              act_ready;
  logic              w_bit;
  logic              w_valid;
  logic              w_ready;
  logic              res_sign;
  logic [EXP_W-1:0]  res_exp;
  logic [MAG_W-1:0]  res_mag;
  logic              res_zero;
  logic              res_special;
  logic              out_valid;
  logic              out_ready;
  logic [ACT_W-1:0]  act_fwd;
  logic              act_fwd_valid;

  modport slave (
    input  act, precision, act_valid, w_bit, w_valid, out_ready,
    output act_ready, w_ready, res_sign, res_exp, res_mag, res_zero, res_special, out_valid,
           act_fwd, act_fwd_valid
  );

  modport master (
    output act, precision, act_valid, w_bit, w_valid, out_ready,
    input  act_ready, w_ready, res_sign, res_exp, res_mag, res_zero, res_special, out_valid,
           act_fwd, act_fwd_valid
  );

endinterface

// File: rtl/fp_int_mul_serial_mac_step.sv
// One Horner step of the MSB-first two's-complement weight multiply.
module serial_mac_step #(
  parameter int unsigned MAN_W = 10,
  parameter int unsigned ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [MAN_W:0]   m_i,
  input  logic                    w_bit_i,
  input  logic                    first_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [ACC_W-1:0] addend;

  always_comb begin
    addend = w_bit_i ? $signed(ACC_W'(m_i)) : '0;
    // The first (sign) bit carries negative weight.
    if (first_i) acc_o = -addend;
    else         acc_o = (acc_i <<< 1) + addend;
  end

endmodule

// File: rtl/fp_int_mul_serial.sv
// Bit-serial FP x INT multiplier: latches one activation, consumes weight bits MSB first and
// emits an exact sign-magnitude fixed-point product with the activation exponent passed through.
module fp_int_mul_serial
  import fp_int_pkg::*;
#(
  parameter int unsigned EXP_W    = Fp16ExpW,
  parameter int unsigned MAN_W    = Fp16ManW,
  parameter int unsigned MAX_PREC = 8,
  parameter int unsigned PREC_W   = 4
) (
  input logic                clk,
  input logic                rst,
  fp_int_mul_serial_if.slave bus
);

  localparam int unsigned ACT_W = 1 + EXP_W + MAN_W;
  localparam int unsigned MAG_W = MAN_W + 1 + MAX_PREC;
  localparam int unsigned ACC_W = MAG_W + 1;

  state_e state_q, state_d;

  logic        [ACT_W-1:0]  act_q;
  logic        [PREC_W-1:0] prec_q;
  logic        [PREC_W-1:0] cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic                     fwd_valid_q;

  logic                     res_sign_q, res_zero_q, res_special_q;
  logic        [EXP_W-1:0]  res_exp_q;
  logic        [MAG_W-1:0]  res_mag_q;

  logic              act_fire, w_fire, last_bit;
  logic [EXP_W-1:0]  act_exp;
  logic [MAN_W:0]    m_op;
  logic [MAG_W-1:0]  mag_nxt;

  assign act_fire = bus.act_valid && bus.act_ready;
  assign w_fire   = bus.w_valid && bus.w_ready;
  assign last_bit = w_fire && ((cnt_q + PREC_W'(1)) == prec_q);

  assign act_exp = act_q[MAN_W +: EXP_W];
  assign m_op    = {(act_exp != '0), act_q[MAN_W-1:0]};

  serial_mac_step #(
    .MAN_W (MAN_W),
    .ACC_W (ACC_W)
  ) u_step (
    .acc_i   (acc_q),
    .m_i     (m_op),
    .w_bit_i (bus.w_bit),
    .first_i (cnt_q == '0),
    .acc_o   (acc_nxt)
  );

  // |acc| always fits MAG_W bits, so the truncation is lossless.
  assign mag_nxt = acc_nxt[ACC_W-1] ? MAG_W'(-acc_nxt) : acc_nxt[MAG_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (act_fire) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = bus.act_valid ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.act_ready = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
    bus.w_ready   = (state_q == StRun);
    bus.out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q         <= '0;
      prec_q        <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      fwd_valid_q   <= 1'b0;
      res_sign_q    <= 1'b0;
      res_exp_q     <= '0;
      res_mag_q     <= '0;
      res_zero_q    <= 1'b0;
      res_special_q <= 1'b0;
    end else begin
      fwd_valid_q <= act_fire;
      if (act_fire) begin
        act_q  <= bus.act;
        prec_q <= PREC_W'(clamp_prec(32'(bus.precision), MAX_PREC));
        cnt_q  <= '0;
        acc_q  <= '0;
      end
      if (w_fire) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q + PREC_W'(1);
      end
      if (last_bit) begin
        res_sign_q    <= (act_q[ACT_W-1] ^ acc_nxt[ACC_W-1]) && (mag_nxt != '0);
        res_exp_q     <= act_exp;
        res_mag_q     <= mag_nxt;
        res_zero_q    <= (mag_nxt == '0);
        res_special_q <= &act_exp;
      end
    end
  end

  assign bus.act_fwd       = act_q;
  assign bus.act_fwd_valid = fwd_valid_q;
  assign bus.res_sign      = res_sign_q;
  assign bus.res_exp       = res_exp_q;
  assign bus.res_mag       = res_mag_q;
  assign bus.res_zero      = res_zero_q;
  assign bus.res_special   = res_special_q;

endmodule

// File: doc/fp_int_mul_serial.md
Name: fp_int_mul_serial

Overview:
Parametrised bit-serial FP x INT multiplier, the successor to the fixed fp16 x int4 multiplier. It latches one floating-point activation and consumes a two's-complement weight one bit per cycle, MSB first, at a runtime precision of 1..MAX_PREC bits. It produces an exact sign-magnitude fixed-point product with a pass-through exponent for the downstream accumulator. Valid/ready handshakes on all three streams and a registered activation forward port let it tile in a systolic row.

Parameters:
EXP_W, 5, activation exponent width
MAN_W, 10, activation stored mantissa width (implicit bit added internally)
MAX_PREC, 8, maximum weight precision in bits
PREC_W, 4, width of precision input; must hold MAX_PREC
(derived localparams: ACT_W = 1+EXP_W+MAN_W; MAG_W = MAN_W+1+MAX_PREC)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
act  in  ACT_W  activation {sign, exponent, mantissa}
precision  in  PREC_W  weight bit count for this operation, sampled with act
act_valid  in  1  act/precision valid
act_ready  out  1  block can accept act
w_bit  in  1  weight bit, MSB (sign) first
w_valid  in  1  w_bit valid
w_ready  out  1  block can accept w_bit
res_sign  out  1  product sign
res_exp  out  EXP_W  activation exponent, passed through
res_mag  out  MAG_W  product magnitude, unsigned fixed point, LSB = 2^-MAN_W of the value
res_zero  out  1  magnitude is zero
res_special  out  1  activation exponent all ones (Inf/NaN)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
act_fwd  out  ACT_W  registered copy of the last accepted act
act_fwd_valid  out  1  one-cycle pulse, the cycle after act is accepted

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; internal accumulator, count and latched act/precision cleared.
- FSM states: IDLE, RUN, DONE.
- act_ready = (state==IDLE) || (state==DONE && out_ready).
- w_ready = (state==RUN). out_valid = (state==DONE).
- Accept act on act_valid && act_ready:
  - latch act and eff_prec;
  - eff_prec = 1 if precision==0, MAX_PREC if precision>MAX_PREC, else precision;
  - clear acc and count; go to RUN; pulse act_fwd_valid next cycle with act_fwd = act.
- Mantissa operand m (MAN_W+1 bits): {1, mantissa} if exponent != 0, else {0, mantissa} (subnormal/zero).
- RUN, on each w_valid && w_ready:
  - first bit (count==0): acc = w_bit ? -m : 0;
  - later bits: acc = (acc<<1) + (w_bit ? m : 0);
  - acc is signed, MAG_W+1 bits; count increments.
  - No overflow is possible by construction.
- w_valid low in RUN: hold; no bit consumed, no timeout.
- When the eff_prec-th bit is accepted:
  - register results: res_sign = act_sign ^ acc_negative, forced to 0 if the magnitude is 0; res_mag = |acc|; res_zero = (res_mag==0); res_exp = latched exponent; res_special = (exponent == all ones);
  - go to DONE.
- Latency: out_valid rises the cycle after the last weight bit is accepted. Gapless throughput: eff_prec+1 cycles per op with back-to-back act acceptance.
- DONE: all res_* outputs held stable while out_valid && !out_ready.
  - out_ready high: result retires.
  - Same cycle act_valid high: new act accepted, next state RUN.
  - Same cycle act_valid low: next state IDLE (out_valid low next cycle).
- res_* outputs keep their last values after retirement and are only updated at the next completion.
- act_valid while in RUN: ignored, because act_ready is low.
- Reset mid-operation: op discarded, no out_valid produced.

Decomposition:
- Shared package fp_int_pkg holds:
  - FP format constants for EXP_W/MAN_W, with fp16 defaults;
  - the FSM state enum {IDLE, RUN, DONE};
  - a function for clamping precision.
- One sub-module, serial_mac_step: combinational Horner step (acc, m, w_bit, first) -> next acc.
- FSM, counter and output registers stay in the top-level module.

Test Plan:
- act=0x3C00, prec=4, bits 0,1,0,1 (+5) -> res_mag=5120, sign=0, exp=15, zero=0, out_valid 1 cycle after 4th bit.
- act=0x3C00, prec=4, bits 1,1,0,1 (-3) -> mag=3072, sign=1; repeat with act=0xBC00 -> mag=3072, sign=0.
- act=0x7BFF, prec=8, bits 1,0,0,0,0,0,0,0 (-128) -> mag=262016 (2047*128), sign=1 (max magnitude); act=0x0001, prec=3, bits 0,1,1 -> mag=3 (subnormal).
- act=0x3C00, prec=0 -> eff_prec=1: bit 1 -> mag=1024, sign=1; prec=12 -> clamped to 8; act=0x8000, any weight -> zero=1, sign=0.
- Hold out_ready low 3 cycles in DONE -> res_* stable, act_ready=0; raise out_ready with act_valid high -> act accepted same cycle, act_fwd_valid pulse next cycle; insert w_valid gaps -> same result.
- Deassert rst during RUN after 2 bits -> all outputs 0, state IDLE, no out_valid; next op computes correctly.
